// File: rtl/banco_registradores_wb.sv
// Write-back stage and 32x32 architectural register file with same-cycle bypass
// on both read ports, a forwarding output and a committed-write counter.

module registradorWb (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end
endmodule

module banco_registradores_wb (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dadoMemoria,
    input  logic [31:0] resultadoALU,
    input  logic [4:0]  rd,
    input  logic        memtoReg,
    input  logic        regWrite,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] dadoRs,
    output logic [31:0] dadoRt,
    output logic [31:0] dadoEscrito,
    output logic        escritaValida,
    output logic [15:0] numEscritas
);
    localparam int NUM_REGS = 32;

    logic [31:0] banco [NUM_REGS];
    logic        bypassAtivo;

    assign dadoEscrito   = memtoReg ? dadoMemoria : resultadoALU;
    assign escritaValida = regWrite && (rd != 5'd0);
    // Bypass is masked during reset so every read port shows the cleared file.
    assign bypassAtivo   = escritaValida && !reset;

    assign banco[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : gReg
        registradorWb uReg (
            .clock (clock),
            .reset (reset),
            .we    (escritaValida && (rd == 5'(g))),
            .d     (dadoEscrito),
            .q     (banco[g])
        );
    end

    always_comb begin
        dadoRs = banco[rs];
        if (rs == 5'd0)                    dadoRs = '0;
        else if (bypassAtivo && rs == rd)  dadoRs = dadoEscrito;
    end

    always_comb begin
        dadoRt = banco[rt];
        if (rt == 5'd0)                    dadoRt = '0;
        else if (bypassAtivo && rt == rd)  dadoRt = dadoEscrito;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)              numEscritas <= '0;
        else if (escritaValida) numEscritas <= numEscritas + 16'd1;
    end
endmodule

// File: doc/banco_registradores_wb.md
# banco_registradores_wb

Write-back stage plus architectural register file: consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32×32-bit register file read by the decode stage. Provides two combinational read ports with same-cycle write bypass, a write-back value output for forwarding, and a committed-write counter for debug. Sits between the MEM/WB register and the ID stage, closing the pipeline loop.

## Interface
- No parameters; register count 32 and data width 32 are fixed.
- clock  in  1  single clock; all state updates on rising edge (MEM/WB updates on falling edge, so inputs are stable half a cycle before each write).
- reset  in  1  asynchronous, active-high; clears all state immediately.
- dadoMemoria  in  32  load data from MEM/WB.
- resultadoALU  in  32  ALU result from MEM/WB.
- rd  in  5  destination register from MEM/WB.
- memtoReg  in  1  1 = write dadoMemoria, 0 = write resultadoALU.
- regWrite  in  1  write enable from MEM/WB.
- rs  in  5  read address port A (ID stage).
- rt  in  5  read address port B (ID stage).
- dadoRs  out  32  read data port A.
- dadoRt  out  32  read data port B.
- dadoEscrito  out  32  current write-back value (forwarding source for EX).
- escritaValida  out  1  regWrite & (rd != 0); a commit happens at next rising edge.
- numEscritas  out  16  count of committed writes.

## Operation
- Write-back mux (combinational): dadoEscrito = memtoReg ? dadoMemoria : resultadoALU, independent of regWrite.
- Commit: at rising edge, if regWrite=1 and rd≠0, register[rd] ← dadoEscrito; numEscritas ← numEscritas+1.
- Register 0 is hardwired zero: writes to rd=0 are discarded, do not increment numEscritas, and escritaValida=0.
- Reads are combinational: dadoRs = (rs==0) ? 0 : (escritaValida && rs==rd) ? dadoEscrito : register[rs]; same for dadoRt with rt.
- Bypass applies to both ports independently and simultaneously (rs==rt==rd returns dadoEscrito on both).
- regWrite=0: no register change regardless of rd/memtoReg; bypass inactive.
- numEscritas wraps 0xFFFF → 0x0000, no saturation, no flag.
- Inputs with X/undefined memtoReg while regWrite=0 must not corrupt state.

## Timing
- Reset (asserted asynchronously, any time): all 32 registers → 0, numEscritas → 0 immediately, without waiting for a clock edge. dadoRs/dadoRt read 0 while reset held (combinational reads of cleared array; bypass still follows inputs, so drive regWrite=0 during reset in benches—decided: bypass is gated by ~reset, so dadoRs/dadoRt = 0 for all addresses during reset).
- Reset asserted coincident with a rising edge: reset wins, no commit.
- Reset deasserted: first commit possible on the first rising edge after deassertion.
- Write latency: value visible on read ports in the same cycle via bypass; from the array starting the cycle after the commit edge.
- Read latency: zero cycles (combinational from rs/rt).
- numEscritas updates on the same edge as the commit.
- One write per cycle maximum; back-to-back writes to the same rd each cycle: last one wins, counter increments each time.

## Test plan
- Reset: assert reset mid-run after writing 0xDEADBEEF to r5 → r5 reads 0, numEscritas=0 without a clock edge; all 32 registers read 0.
- Mux and commit: regWrite=1, rd=7, memtoReg=0, resultadoALU=0x12345678, dadoMemoria=0xAAAA5555 → after edge rs=7 reads 0x12345678; repeat with memtoReg=1 → 0xAAAA5555; numEscritas=2.
- Register zero: regWrite=1, rd=0, value 0xFFFFFFFF → rs=0 reads 0, escritaValida=0, numEscritas unchanged.
- Bypass: rd=9, regWrite=1, resultadoALU=0xCAFEF00D, rs=rt=9 before edge → both ports read 0xCAFEF00D combinationally; with regWrite=0 they read the old r9.
- Write-enable off: regWrite=0, rd=3, value 0x1 → r3 unchanged, counter unchanged.
- Counter wrap: 65536 consecutive writes to r1 → numEscritas returns to 0x0000; r1 holds the last value.
